// File: rtl/phase_det_pkg.sv
// Shared defaults, sign encoding and arithmetic helpers for the I/V phase detector.
package phase_det_pkg;

   localparam int DEF_NLANE   = 4;
   localparam int DEF_WIN_CYC = 16;
   localparam int DEF_TH_W    = 8;
   localparam int DEF_FSHIFT  = 2;

   typedef enum logic {
      PH_LEAD = 1'b0,
      PH_LAG  = 1'b1
   } phase_sign_e;

   function automatic int popcount(input logic [31:0] v);
      int n;
      n = 0;
      for (int k = 0; k < 32; k++) begin
         if (v[k]) n++;
      end
      return n;
   endfunction

   function automatic int sat_int(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/phase_lpf.sv
// First-order IIR smoother for the window phase, with a bypass that preloads
// the state so switching between modes produces no step.
module phase_lpf
   import phase_det_pkg::*;
#(
   parameter int TH_W   = DEF_TH_W,
   parameter int FSHIFT = DEF_FSHIFT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic signed [TH_W-1:0] x,
   input  logic                   x_vld,
   input  logic                   bypass,
   output logic signed [TH_W-1:0] theta_f,
   output logic                   theta_f_vld
);

   localparam int AF_W   = TH_W + FSHIFT + 1;
   localparam int AF_MAX = (1 <<< (AF_W - 1)) - 1;
   localparam int AF_MIN = -(1 <<< (AF_W - 1));
   localparam int TH_MAX = (1 <<< (TH_W - 1)) - 1;
   localparam int TH_MIN = -(1 <<< (TH_W - 1));

   logic signed [AF_W-1:0] acc_f;
   logic signed [TH_W-1:0] x_prev;
   int                     avg;
   int                     acc_next;

   // Averaging x(k) with x(k-1) adds a zero at Nyquist; acc_f carries FSHIFT
   // fractional bits so the DC gain stays exactly one.
   always_comb begin
      avg      = (int'(x) + int'(x_prev)) >>> 1;
      acc_next = int'(acc_f) - (int'(acc_f) >>> FSHIFT) + avg;
      if (bypass) acc_next = int'(x) <<< FSHIFT;
      acc_next = sat_int(acc_next, AF_MIN, AF_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_f       <= '0;
         x_prev      <= '0;
         theta_f_vld <= 1'b0;
      end else begin
         theta_f_vld <= x_vld;
         if (x_vld) begin
            acc_f  <= AF_W'(acc_next);
            x_prev <= x;
         end
      end
   end

   assign theta_f = TH_W'(sat_int(int'(acc_f) >>> FSHIFT, TH_MIN, TH_MAX));

endmodule

// File: rtl/phase_detector_param.sv
// Parametrised I/V phase detector: XOR-counts sign lanes over a window and
// resolves the phase sign with a quarter-period-delayed copy of I.
module phase_detector_param
   import phase_det_pkg::*;
#(
   parameter int NLANE   = DEF_NLANE,
   parameter int WIN_CYC = DEF_WIN_CYC,
   parameter int QDLY    = WIN_CYC / 4,
   parameter int TH_W    = DEF_TH_W,
   parameter int FSHIFT  = DEF_FSHIFT,
   parameter int ACC_W   = $clog2(2 * NLANE * WIN_CYC + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NLANE-1:0]       I,
   input  logic [NLANE-1:0]       V,
   input  logic                   win_pulse,
   input  logic                   bypass,
   output logic signed [TH_W-1:0] theta_raw,
   output logic                   theta_vld,
   output logic signed [TH_W-1:0] theta_f,
   output logic                   theta_f_vld,
   output logic                   win_err
);

   localparam int HALF    = NLANE * WIN_CYC;
   localparam int ACC_MAX = 2 * HALF;
   localparam int CYC_MAX = 2 * WIN_CYC;
   localparam int CYC_W   = $clog2(CYC_MAX + 1);

   logic [NLANE-1:0] dly [QDLY];
   logic [ACC_W-1:0] acc1;
   logic [ACC_W-1:0] acc2;
   logic [CYC_W-1:0] cyc;
   int               s1;
   int               s2;
   int               mag;
   int               raw_next;
   phase_sign_e      ph_sign;
   logic             err_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < QDLY; k++) dly[k] <= '0;
      end else begin
         dly[0] <= I;
         for (int k = 1; k < QDLY; k++) dly[k] <= dly[k-1];
      end
   end

   // The closing cycle's samples are folded in here, so the window result
   // and the next accumulator value both come from the same saturated sums.
   // A large delayed-I mismatch means I lags V, reported as negative phase.
   always_comb begin
      s1       = sat_int(int'(acc1) + popcount(32'(I ^ V)), 0, ACC_MAX);
      s2       = sat_int(int'(acc2) + popcount(32'(dly[QDLY-1] ^ V)), 0, ACC_MAX);
      mag      = (s1 < HALF) ? s1 : HALF;
      ph_sign  = (s2 >= HALF / 2) ? PH_LAG : PH_LEAD;
      raw_next = (ph_sign == PH_LAG) ? -mag : mag;
      err_next = (cyc == CYC_W'(CYC_MAX)) || (s1 >= ACC_MAX) || (s2 >= ACC_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc1 <= '0;
         acc2 <= '0;
         cyc  <= '0;
      end else if (win_pulse) begin
         acc1 <= '0;
         acc2 <= '0;
         cyc  <= '0;
      end else begin
         acc1 <= ACC_W'(s1);
         acc2 <= ACC_W'(s2);
         if (cyc != CYC_W'(CYC_MAX)) cyc <= cyc + CYC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         theta_raw <= '0;
         theta_vld <= 1'b0;
         win_err   <= 1'b0;
      end else begin
         theta_vld <= win_pulse;
         if (win_pulse) begin
            theta_raw <= TH_W'(raw_next);
            win_err   <= err_next;
         end
      end
   end

   phase_lpf #(
      .TH_W   (TH_W),
      .FSHIFT (FSHIFT)
   ) u_lpf (
      .clk         (clk),
      .rst_n       (rst_n),
      .x           (theta_raw),
      .x_vld       (theta_vld),
      .bypass      (bypass),
      .theta_f     (theta_f),
      .theta_f_vld (theta_f_vld)
   );

endmodule

// File: tb/tb_phase_detector_param.sv
// Scoreboard bench for phase_detector_param: a behavioural model queues the
// expected window results as stimulus is driven; a monitor pops them on strobes.
module tb_phase_detector_param;

   localparam int NLANE   = 4;
   localparam int WIN_CYC = 16;
   localparam int QDLY    = 4;
   localparam int TH_W    = 8;
   localparam int FSHIFT  = 2;
   localparam int HALF    = NLANE * WIN_CYC;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NLANE-1:0]       I;
   logic [NLANE-1:0]       V;
   logic                   win_pulse;
   logic                   bypass;
   logic signed [TH_W-1:0] theta_raw;
   logic                   theta_vld;
   logic signed [TH_W-1:0] theta_f;
   logic                   theta_f_vld;
   logic                   win_err;

   phase_detector_param #(
      .NLANE   (NLANE),
      .WIN_CYC (WIN_CYC),
      .QDLY    (QDLY),
      .TH_W    (TH_W),
      .FSHIFT  (FSHIFT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .I           (I),
      .V           (V),
      .win_pulse   (win_pulse),
      .bypass      (bypass),
      .theta_raw   (theta_raw),
      .theta_vld   (theta_vld),
      .theta_f     (theta_f),
      .theta_f_vld (theta_f_vld),
      .win_err     (win_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int t;

   int               acc1_m, acc2_m, cyc_m, accf_m, prev_m, pend_raw;
   logic             pend_m;
   logic [NLANE-1:0] hist_m[$];
   int               exp_raw_q[$], exp_err_q[$], exp_f_q[$];
   int               obs_raw[$], obs_err[$], obs_f[$];

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [NLANE-1:0] sqr(input int x);
      if ((x % 16) < 8) return '1;
      return '0;
   endfunction

   task automatic modelReset();
      acc1_m = 0; acc2_m = 0; cyc_m = 0; accf_m = 0; prev_m = 0;
      pend_m = 1'b0; pend_raw = 0;
      hist_m.delete();
      repeat (QDLY) hist_m.push_back('0);
      exp_raw_q.delete(); exp_err_q.delete(); exp_f_q.delete();
   endtask

   // One clock of the reference behaviour; the filter lags one cycle behind the raw result.
   task automatic modelStep(input logic [NLANE-1:0] iv, input logic [NLANE-1:0] vv,
                            input logic wp);
      logic [NLANE-1:0] idl;
      int s1, s2, mag, raw;
      if (pend_m) begin
         if (bypass) accf_m = pend_raw * 4;
         else        accf_m = accf_m - (accf_m >>> FSHIFT) + ((pend_raw + prev_m) >>> 1);
         prev_m = pend_raw;
         exp_f_q.push_back(accf_m >>> FSHIFT);
         pend_m = 1'b0;
      end
      idl = hist_m.pop_front();
      hist_m.push_back(iv);
      s1 = acc1_m + $countones(iv ^ vv);
      s2 = acc2_m + $countones(idl ^ vv);
      if (s1 > 2 * HALF) s1 = 2 * HALF;
      if (s2 > 2 * HALF) s2 = 2 * HALF;
      if (wp) begin
         mag = (s1 > HALF) ? HALF : s1;
         raw = (s2 >= HALF / 2) ? -mag : mag;
         exp_raw_q.push_back(raw);
         exp_err_q.push_back((cyc_m >= 2 * WIN_CYC || s1 >= 2 * HALF || s2 >= 2 * HALF) ? 1 : 0);
         pend_m = 1'b1; pend_raw = raw;
         acc1_m = 0; acc2_m = 0; cyc_m = 0;
      end else begin
         acc1_m = s1; acc2_m = s2;
         if (cyc_m < 2 * WIN_CYC) cyc_m++;
      end
   endtask

   // Modes: 0 I==V random, 1 I lags V by 4, 2 I leads V by 4, 3 I = ~V constant.
   task automatic applyStimulus(input int mode, input logic wp);
      logic [NLANE-1:0] iv, vv;
      case (mode)
         0:       begin vv = NLANE'($urandom); iv = vv; end
         1:       begin vv = sqr(t); iv = sqr(t + 12); end
         2:       begin vv = sqr(t); iv = sqr(t + 4); end
         default: begin vv = NLANE'(6); iv = ~vv; end
      endcase
      @(negedge clk);
      I = iv; V = vv; win_pulse = wp;
      modelStep(iv, vv, wp);
      t++;
   endtask

   task automatic runWindows(input int mode, input int nwin);
      int p;
      logic wp;
      p = 0;
      while (p < nwin) begin
         wp = ((t % 16) == 15);
         applyStimulus(mode, wp);
         if (wp) p++;
      end
      repeat (3) applyStimulus(mode, 1'b0);
      #1;
   endtask

   task automatic releaseReset();
      @(negedge clk);
      I = '0; V = '0; win_pulse = 1'b0; rst_n = 1'b1;
      modelReset();
      modelStep('0, '0, 1'b0);
      t = 0;
   endtask

   task automatic clearObs();
      obs_raw.delete(); obs_err.delete(); obs_f.delete();
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (theta_vld) begin
            obs_raw.push_back(int'(theta_raw));
            obs_err.push_back(int'(win_err));
            checkOutput("raw_expected", int'(exp_raw_q.size() > 0), 1);
            if (exp_raw_q.size() > 0) begin
               checkOutput("theta_raw", int'(theta_raw), exp_raw_q.pop_front());
               checkOutput("win_err", int'(win_err), exp_err_q.pop_front());
            end
         end
         if (theta_f_vld) begin
            obs_f.push_back(int'(theta_f));
            checkOutput("f_expected", int'(exp_f_q.size() > 0), 1);
            if (exp_f_q.size() > 0) checkOutput("theta_f", int'(theta_f), exp_f_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n = 1'b0; I = '0; V = '0; win_pulse = 1'b0; bypass = 1'b0; t = 0;
      modelReset();
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_theta_raw", int'(theta_raw), 0);
      checkOutput("rst_theta_vld", int'(theta_vld), 0);
      checkOutput("rst_theta_f", int'(theta_f), 0);
      checkOutput("rst_theta_f_vld", int'(theta_f_vld), 0);
      checkOutput("rst_win_err", int'(win_err), 0);
      releaseReset();

      $display("[TB] I == V random windows");
      clearObs();
      runWindows(0, 4);
      checkOutput("eq_count", obs_raw.size(), 4);
      foreach (obs_raw[k]) checkOutput("eq_raw_zero", obs_raw[k], 0);
      foreach (obs_err[k]) checkOutput("eq_err_zero", obs_err[k], 0);

      $display("[TB] I lags / leads V by a quarter period");
      clearObs();
      runWindows(1, 3);
      checkOutput("lag_raw", obs_raw[2], -32);
      clearObs();
      runWindows(2, 3);
      checkOutput("lead_raw", obs_raw[2], 32);

      $display("[TB] I = ~V full-scale and overrun");
      clearObs();
      runWindows(3, 3);
      checkOutput("anti_raw", obs_raw[2], -64);
      clearObs();
      repeat (39) applyStimulus(3, 1'b0);
      applyStimulus(3, 1'b1);
      repeat (3) applyStimulus(3, 1'b0);
      #1;
      checkOutput("sat_raw", obs_raw[0], -64);
      checkOutput("sat_err", obs_err[0], 1);
      clearObs();
      runWindows(0, 1);
      checkOutput("post_sat_err", obs_err[0], 0);

      $display("[TB] back-to-back window pulses");
      clearObs();
      repeat (3) applyStimulus(2, 1'b1);
      repeat (3) applyStimulus(2, 1'b0);
      #1;
      checkOutput("b2b_count", obs_raw.size(), 3);
      checkOutput("b2b_f_count", obs_f.size(), 3);

      $display("[TB] reset mid-window");
      runWindows(1, 2);
      repeat (5) applyStimulus(1, 1'b0);
      #2;
      rst_n = 1'b0; I = '0; V = '0; win_pulse = 1'b1;
      #1;
      checkOutput("arst_theta_raw", int'(theta_raw), 0);
      checkOutput("arst_theta_f", int'(theta_f), 0);
      checkOutput("arst_win_err", int'(win_err), 0);
      checkOutput("arst_theta_vld", int'(theta_vld), 0);
      checkOutput("arst_theta_f_vld", int'(theta_f_vld), 0);
      repeat (2) @(negedge clk);
      releaseReset();

      $display("[TB] filter step response from reset");
      clearObs();
      runWindows(2, 20);
      checkOutput("fresh_raw", obs_raw[0], 32);
      checkOutput("fresh_err", obs_err[0], 0);
      checkOutput("lpf_w1", obs_f[0], 4);
      checkOutput("lpf_w2", obs_f[1], 11);
      checkOutput("lpf_w3", obs_f[2], 16);
      checkOutput("lpf_w20", obs_f[19], 32);

      $display("[TB] bypass switching");
      bypass = 1'b1;
      clearObs();
      runWindows(2, 1);
      checkOutput("byp_lead_f", obs_f[0], 32);
      clearObs();
      runWindows(1, 2);
      checkOutput("byp_lag_f", obs_f[1], -32);
      bypass = 1'b0;
      clearObs();
      runWindows(1, 1);
      checkOutput("unbyp_f", obs_f[0], -32);

      repeat (4) applyStimulus(0, 1'b0);
      #1;
      checkOutput("raw_q_drained", exp_raw_q.size(), 0);
      checkOutput("f_q_drained", exp_f_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/phase_detector_param.md
Name: phase_detector_param

Overview:
Parametrised successor to the four-lane I/V phase detector. It XOR-counts the binary current (I) and voltage (V) sign lanes over one window, and uses a quarter-period-delayed copy of I to resolve the sign of the phase. It outputs a raw signed phase with a valid strobe and an optionally low-pass-filtered phase. It sits between the lane samplers and the frequency-locking loop controller, all on one clock.

Parameters:
NLANE, 4, sign bits per sample per signal (sub-sample lanes)
WIN_CYC, 16, clock cycles per nominal window (one signal period); full scale HALF = NLANE*WIN_CYC maps to 180 deg
QDLY, 4, quarter-period delay of I in clock cycles (WIN_CYC/4)
TH_W, 8, signed phase output width; requires HALF <= 2^(TH_W-1)-1
FSHIFT, 2, IIR pole shift; pole = 1 - 2^-FSHIFT (2 gives pole 0.75)
ACC_W, $clog2(2*HALF+1), accumulator width (derived)

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
I  in  NLANE  current sign lanes, valid every clk
V  in  NLANE  voltage sign lanes, valid every clk
win_pulse  in  1  single-cycle window-close strobe, synchronous to clk
bypass  in  1  1: theta_f follows theta_raw; 0: IIR filter active
theta_raw  out  TH_W  signed phase of last closed window
theta_vld  out  1  one-cycle strobe, theta_raw updated
theta_f  out  TH_W  filtered phase
theta_f_vld  out  1  one-cycle strobe, theta_f updated
win_err  out  1  last closed window overran (no win_pulse within 2*WIN_CYC cycles)

Behaviour:
- Reset (rst_n low, async): delay line, accumulators, cycle counter, filter state, previous-sample register and all outputs go to 0.
- Delay line: QDLY-stage shift register of I; Id = I delayed QDLY clocks.
- Each cycle, the combinational sums are s1 = acc1 + popcount(I^V) and s2 = acc2 + popcount(Id^V).
- Accumulators saturate at 2*HALF and never wrap.
- Non-window cycles: acc1 <= s1, acc2 <= s2, cyc <= cyc+1 (saturates at 2*WIN_CYC).
- Window close (win_pulse=1 at cycle T): the current cycle's samples are included via s1/s2.
  - Accumulators and cyc clear to 0.
  - mag = min(s1, HALF).
  - theta_raw (at T+1) = -mag if s2 >= HALF/2, else +mag. Current lagging voltage gives negative phase.
  - mag = 0 yields exactly 0, never -2^(TH_W-1).
  - win_err (at T+1) = 1 if cyc reached 2*WIN_CYC or either accumulator saturated, else 0.
  - theta_vld = 1 at T+1 only.
- Filter, updated at T+2 from theta_raw(k) and prev x(k-1):
  - acc_f <= acc_f - (acc_f >>> FSHIFT) + ((x(k)+x(k-1)) >>> 1).
  - acc_f width is TH_W+FSHIFT+1; saturate.
  - theta_f = acc_f >>> FSHIFT. DC gain is 1.
  - x(k-1) <= x(k).
  - bypass=1: theta_f = theta_raw, acc_f <= theta_raw<<FSHIFT, so there is no transient on switching.
  - theta_f_vld = 1 at T+2 only.
- Back-to-back win_pulse (consecutive cycles): each closes a window. Second result uses one cycle of samples; pipeline accepts one window per cycle.
- win_pulse during reset is ignored. The first window after reset counts from reset release.

Decomposition:
- Package phase_det_pkg: default NLANE/WIN_CYC/TH_W constants, popcount function, signed saturate function.
- Sub-module phase_lpf (filter with acc_f, x(k-1), bypass and theta_f_vld); the top holds the delay line, accumulators and sign decision.

Test Plan:
- I == V, random lanes, win_pulse every 16 cycles -> theta_raw = 0, win_err = 0, theta_vld at T+1.
- Square wave period 16 cycles, all lanes equal, I lags V by 4 cycles -> s1 = 32, s2 = 64 -> theta_raw = -32. I leads V by 4 -> +32.
- I = ~V constant -> s1 = 64, s2 = 64 -> theta_raw = -64, never -128.
- bypass=0, theta_raw held at 32 from reset -> theta_f = 4, 11, 16, ... converging to 32 within 20 windows. bypass=1 -> theta_f = 32 at T+2.
- win_pulse held low 40 cycles with I = ~V -> accumulators saturate at 128, theta_raw = -64, win_err = 1. Next normal window -> win_err = 0.
- rst_n asserted mid-window -> all outputs 0 immediately (asynchronously). After release, the first window result equals a fresh-window result with no carry-over.
